// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare predictor: FSM states, counter
// arithmetic and the table index function.
package bp_pkg;

  typedef enum logic {INIT, RUN} bp_state_e;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic logic [3:0] ctr_init(input int cb);
    return 4'((1 << (cb - 1)) - 1);
  endfunction

  function automatic logic [3:0] ctr_next(input logic [3:0] ctr, input logic taken, input int cb);
    logic [3:0] mx;
    mx = 4'((1 << cb) - 1);
    if (taken) return (ctr == mx) ? ctr : ctr + 4'd1;
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

  // Caller truncates to INDEX_BITS; hist arrives zero-extended.
  function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] hist,
                                           input logic gshare_en);
    return gshare_en ? (pc ^ hist) : pc;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: async read for fetch, sync read-modify-write port
// that either loads the init value or applies a saturating step.
module bp_pht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] i_raddr,
  output logic [CTR_BITS-1:0]   o_rdata,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_waddr,
  input  logic                  i_winit,
  input  logic                  i_wtaken
);

  logic [CTR_BITS-1:0] r_mem [2**INDEX_BITS];
  logic [CTR_BITS-1:0] w_wdata;

  assign o_rdata = r_mem[i_raddr];

  always_comb begin
    w_wdata = CTR_BITS'(ctr_next(4'(r_mem[i_waddr]), i_wtaken, CTR_BITS));
    if (i_winit) w_wdata = CTR_BITS'(ctr_init(CTR_BITS));
  end

  // No reset on the array so it can map onto RAM; the INIT sweep fills it.
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= w_wdata;

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal branch predictor: fetch lookup, resolve-stage training,
// speculative GHR with mispredict restore, post-reset table init sweep.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 4,
  parameter int CTR_BITS   = 2,
  parameter int GSHARE_EN  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic                 ready,
  output logic [15:0]          mispredict_count
);

  localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
  localparam logic                  GS       = (GSHARE_EN != 0);

  bp_state_e             r_state, w_state_nxt;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [HIST_BITS-1:0]  r_ghr;
  logic [15:0]           r_miss_cnt;
  logic [INDEX_BITS-1:0] w_pred_idx, w_upd_idx, w_waddr;
  logic [CTR_BITS-1:0]   w_pred_ctr;
  logic                  w_run, w_miss, w_we;

  assign w_pred_idx = INDEX_BITS'(bp_index(32'(pred_pc), 32'(r_ghr), GS));
  assign w_upd_idx  = INDEX_BITS'(bp_index(32'(upd_pc), 32'(upd_hist), GS));
  assign w_run      = (r_state == RUN);
  assign w_miss     = w_run & upd_valid & upd_mispredict;
  assign w_we       = !w_run | upd_valid;
  assign w_waddr    = w_run ? w_upd_idx : r_ptr;

  bp_pht #(.INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS)) u_pht (
    .clk      (clk),
    .i_raddr  (w_pred_idx),
    .o_rdata  (w_pred_ctr),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_winit  (!w_run),
    .i_wtaken (upd_taken)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_ptr == PTR_LAST) w_state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run) r_ptr <= r_ptr + INDEX_BITS'(1);
    end
  end

  // Restore beats the speculative shift; the truncating casts also cover HIST_BITS=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_ghr <= '0;
    else if (w_miss)              r_ghr <= HIST_BITS'({upd_hist, upd_taken});
    else if (w_run && pred_valid) r_ghr <= HIST_BITS'({r_ghr, pred_taken});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_miss_cnt <= '0;
    else if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
  end

  assign pred_taken       = w_run & w_pred_ctr[CTR_BITS-1];
  assign pred_hist        = r_ghr;
  assign ready            = w_run;
  assign mispredict_count = r_miss_cnt;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench: u0 is gshare/2-bit, u1 is bimodal/3-bit, sharing stimulus.
module tb_gshare_branch_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic       pred_valid, upd_valid, upd_taken, upd_mispredict;
  logic [7:0] pred_pc, upd_pc;
  logic [3:0] upd_hist;
  logic       pt0, pt1, rdy0, rdy1;
  logic [3:0] ph0, ph1;
  logic [15:0] mc0, mc1;

  typedef struct { string name; string sig; logic [15:0] exp; } sb_t;
  sb_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor #(.GSHARE_EN(1), .CTR_BITS(2)) u0 (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pt0), .pred_hist(ph0), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_hist(upd_hist), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ready(rdy0), .mispredict_count(mc0));

  gshare_branch_predictor #(.GSHARE_EN(0), .CTR_BITS(3)) u1 (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pt1), .pred_hist(ph1), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_hist(upd_hist), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ready(rdy1), .mispredict_count(mc1));

  function automatic logic [15:0] probe(input string s);
    case (s)
      "pt0":  return 16'(pt0);
      "pt1":  return 16'(pt1);
      "ph0":  return 16'(ph0);
      "rdy0": return 16'(rdy0);
      "rdy1": return 16'(rdy1);
      "mc0":  return mc0;
      "mc1":  return mc1;
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic push_exp(input string n, input string s, input logic [15:0] v);
    sb_t e;
    e.name = n; e.sig = s; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_hist = 0; upd_taken = 0; upd_mispredict = 0;
  endtask

  task automatic test_reset();
    sb_t e; logic [15:0] obs;
    idle(); reset = 1; tick(); tick();
    push_exp("reset", "rdy0", 0); push_exp("reset", "mc0", 0);
    push_exp("reset", "ph0", 0);  push_exp("reset", "pt0", 0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    reset = 0;
    // Inputs toggle throughout INIT; late mispredicting updates target 0x10.
    for (int k = 1; k <= 256; k++) begin
      pred_valid = 1; pred_pc = 8'($urandom);
      upd_valid = (k > 200); upd_pc = 8'h10; upd_hist = 4'hF; upd_taken = 1; upd_mispredict = 1;
      push_exp("init", "pt0", 0); push_exp("init", "pt1", 0); push_exp("init", "ph0", 0);
      if (k == 256) push_exp("init_last", "rdy0", 0);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
        if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
      end
      tick();
    end
    idle(); pred_pc = 8'h10;
    push_exp("run", "rdy0", 1); push_exp("run", "rdy1", 1); push_exp("run", "ph0", 0);
    push_exp("run", "mc0", 0);  push_exp("run", "mc1", 0);
    push_exp("init_upd_ignored", "pt0", 0); push_exp("init_upd_ignored", "pt1", 0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
  endtask

  task automatic test_counter();
    sb_t e; logic [15:0] obs;
    logic [6:0] tk   = 7'b1000011;  // bit i = outcome of update i
    logic [6:0] exp0 = 7'b0000111;
    logic [6:0] exp1 = 7'b0000111;
    for (int i = 0; i < 7; i++) begin
      idle(); upd_valid = 1; upd_pc = 8'h10; upd_taken = tk[i];
      tick();
      idle(); pred_pc = 8'h10;
      push_exp($sformatf("ctr2_step%0d", i), "pt0", 16'(exp0[i]));
      push_exp($sformatf("ctr3_step%0d", i), "pt1", 16'(exp1[i]));
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
        if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
      end
    end
  endtask

  task automatic test_ctr3();
    sb_t e; logic [15:0] obs;
    idle(); pred_pc = 8'h22;
    push_exp("ctr3_init", "pt1", 0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    // From 3: ten taken saturate at 7, then 6,5,4 still taken, 3 not.
    for (int i = 0; i < 14; i++) begin
      idle(); upd_valid = 1; upd_pc = 8'h22; upd_hist = 4'hA; upd_taken = (i < 10);
      tick();
      idle(); pred_pc = 8'h22;
      push_exp($sformatf("ctr3_sat%0d", i), "pt1", 16'(i < 13));
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
        if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
      end
    end
  endtask

  task automatic test_ghr();
    sb_t e; logic [15:0] obs;
    logic [7:0] pcs [3] = '{8'h50, 8'h60, 8'h52};
    logic [2:0] ept = 3'b101;
    idle(); upd_valid = 1; upd_pc = 8'h50; upd_taken = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); pred_valid = 1; pred_pc = pcs[i];
      push_exp($sformatf("ghr_pred%0d", i), "pt0", 16'(ept[2-i]));
      push_exp($sformatf("ghr_hist%0d", i), "ph0", 16'(i));
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
        if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
      end
      tick();
    end
    idle();
    push_exp("ghr_final", "ph0", 16'h5);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    upd_valid = 1; upd_mispredict = 1; upd_hist = 4'b0001; upd_taken = 0; upd_pc = 8'h70;
    pred_valid = 1; pred_pc = 8'h50;
    tick();
    idle();
    push_exp("ghr_restore", "ph0", 16'h2); push_exp("miss_cnt", "mc0", 1); push_exp("miss_cnt", "mc1", 1);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
  endtask

  task automatic test_same_index();
    sb_t e; logic [15:0] obs;
    idle(); upd_valid = 1; upd_mispredict = 1; upd_hist = 4'b0001; upd_taken = 1; upd_pc = 8'h10;
    tick();
    idle(); pred_pc = 8'h40; upd_valid = 1; upd_pc = 8'h40; upd_hist = 4'h3; upd_taken = 1;
    push_exp("same_idx_old", "pt0", 0); push_exp("same_idx_hist", "ph0", 16'h3);
    push_exp("same_idx_cnt", "mc0", 2);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    tick();
    idle(); pred_pc = 8'h40;
    push_exp("same_idx_new", "pt0", 1);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    pred_pc = 8'h43;  // hashes to 0x40, which is still untouched
    push_exp("xor_index", "pt0", 0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
  endtask

  task automatic test_reset_mid_init();
    sb_t e; logic [15:0] obs;
    idle(); reset = 1; tick(); reset = 0;
    repeat (100) tick();
    reset = 1;
    push_exp("mid_rst", "rdy0", 0); push_exp("mid_rst", "mc0", 0); push_exp("mid_rst", "ph0", 0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    tick(); reset = 0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 128 || k == 256) push_exp($sformatf("reinit%0d", k), "rdy0", 0);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
        if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
      end
      tick();
    end
    pred_pc = 8'h43;
    push_exp("reinit_done", "rdy0", 1); push_exp("reinit_entry", "pt0", 0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
  endtask

  task automatic test_miss_sat();
    sb_t e; logic [15:0] obs;
    idle(); upd_valid = 1; upd_mispredict = 1;
    repeat (65534) tick();
    push_exp("miss_pre_sat", "mc0", 16'hFFFE); push_exp("miss_pre_sat", "mc1", 16'hFFFE);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
    repeat (6) tick();
    idle();
    push_exp("miss_sat", "mc0", 16'hFFFF); push_exp("miss_sat", "mc1", 16'hFFFF);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = probe(e.sig); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s.%s: got %0h want %0h", e.name, e.sig, obs, e.exp); end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); reset = 1;
    test_reset();
    test_counter();
    test_ctr3();
    test_ghr();
    test_same_index();
    test_reset_mid_init();
    test_miss_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
Parametrised successor to the fetch-stage 2-bit BHT predictor. It predicts at fetch and trains from the resolve stage.
- Adds N-bit saturating counters and a global history register (GHR) XOR-folded into the index (gshare), switchable to plain bimodal.
- Adds a speculative GHR with checkpoint recovery on mispredict.
- Adds a sequential table-init sweep after reset, so the pattern table can infer as RAM.
- Adds a mispredict statistics counter.

Parameters:
- PC_WIDTH, 8, width of fetch/resolve PC inputs.
- INDEX_BITS, 8, log2 of pattern table depth; must be <= PC_WIDTH.
- HIST_BITS, 4, GHR length; legal range 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width; legal range 2..4.
- GSHARE_EN, 1, 1 = index is PC XOR GHR; 0 = index is PC only (GHR still tracked).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pred_valid  in  1  fetch lookup this cycle.
- pred_pc  in  PC_WIDTH  fetch PC.
- pred_taken  out  1  prediction, combinational from table.
- pred_hist  out  HIST_BITS  GHR snapshot used for this lookup; pipelined with the branch.
- upd_valid  in  1  resolved branch this cycle.
- upd_pc  in  PC_WIDTH  PC of resolved branch.
- upd_hist  in  HIST_BITS  pred_hist carried with that branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  resolve stage flags a wrong prediction; qualified by upd_valid.
- ready  out  1  high once table init is complete.
- mispredict_count  out  16  saturating count of mispredicts.

Behaviour:
- Index functions:
  - pred index = pred_pc[INDEX_BITS-1:0] XOR zero-extended GHR when GSHARE_EN, otherwise pred_pc[INDEX_BITS-1:0].
  - upd index is the same function of upd_pc and upd_hist.
  - Update never uses the fetch PC.
- Counters: unsigned CTR_BITS. Predict taken iff MSB = 1. Init value WNT = 2^(CTR_BITS-1)-1.
- FSM states: INIT and RUN.
  - Async reset gives state=INIT, ptr=0, GHR=0, mispredict_count=0.
  - INIT: write WNT to entry ptr each cycle, ptr++. Leave for RUN on the cycle the entry at 2^INDEX_BITS-1 is written. Init lasts exactly 2^INDEX_BITS cycles.
  - In INIT: ready=0, pred_taken=0, pred_valid and upd_valid are ignored (no GHR shift, no counter write, no count).
  - Reset asserted mid-INIT or mid-RUN restarts INIT from ptr 0.
- Reset/INIT output values: pred_taken=0, pred_hist=0, ready=0, mispredict_count=0.
- Predict (RUN): zero-cycle latency, combinational read. pred_hist = GHR before shift. If pred_valid, the GHR is updated on the next edge to {GHR[HIST_BITS-2:0], pred_taken}.
- Update (RUN, upd_valid):
  - The counter at upd index saturates: +1 if upd_taken (hold at 2^CTR_BITS-1), -1 if not taken (hold at 0).
- Mispredict (upd_valid & upd_mispredict):
  - GHR is restored to {upd_hist[HIST_BITS-2:0], upd_taken}.
  - This has priority over a same-cycle pred_valid shift.
  - mispredict_count increments, holding at 0xFFFF.
- Same-cycle predict and update to the same index: pred_taken reflects the pre-update value (no bypass). The new value is visible next cycle.
- With HIST_BITS=1, the GHR shift is GHR <= pred_taken.
- No X on outputs after reset. All table writes occur on clk only.

Decomposition:
- Package bp_pkg holds:
  - the state enum {INIT, RUN};
  - the function ctr_init(CTR_BITS) returning WNT;
  - the function ctr_next(ctr, taken, CTR_BITS) for saturating update;
  - the function bp_index(pc, hist, GSHARE_EN).
- Sub-module bp_pht: 2^INDEX_BITS x CTR_BITS table with one async read port and one sync write port.
  - The top muxes the write port between the INIT sweep and the update path.

Test Plan:
- Reset pulse, then idle → ready=0 for 256 cycles and goes high on cycle 257. pred_taken=0 for any pred_pc during INIT. upd_valid in INIT leaves entries at 01.
- GSHARE_EN=0, pc 0x10: upd taken x1 → pred_taken=1 (ctr 10). Taken x1 more → 11. Not-taken x2 → 01, pred_taken=0. Not-taken x2 more → 00, stays 00.
- CTR_BITS=3, pc 0x22: 10 taken updates → ctr 7 (saturated). One not-taken → 6, pred_taken still 1. Init value checked as 3.
- GHR=0: pred_valid x3 with predictions 1,0,1 → pred_hist 0000, 0001, 0010, final GHR 0101. Then mispredict with upd_hist 0001, upd_taken 0, plus same-cycle pred_valid → GHR 0010 next cycle.
- GSHARE_EN=1, GHR=0011: pred_pc 0x40 reads index 0x43. Same-cycle update to index 0x43 taken → pred_taken shows the old MSB this cycle and the new MSB next cycle.
- Reset asserted at ptr=100 during INIT → restart, ready low a full 256 cycles. In RUN, 65540 mispredicts → mispredict_count holds 0xFFFF.
